ex_mem_split: RTL and testbench

Memory-request staging block that sits directly downstream of the EX address-generation unit. It takes the 48-bit effective address together with the same `idUIxt` access descriptor. It then issues one or two line-relative requests to the L1 data port, splitting any access that crosses a 16-byte line. For loads, it merges the returned line data into a sign- or zero-extended 64-bit result. Conditional (CC) suppression is resolved here, so predicated-off accesses produce no memory traffic.

---
 rtl/ex_mem_split.sv | 183 ++++++++++++++++++
 tb/tb_ex_mem_split.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_split.sv
// ex_mem_split: stages one AGU access into one or two line-relative L1 requests
// and merges returned line data into an extended 64-bit load result.
module ex_mem_split (
    input  logic         clock,
    input  logic         reset,
    input  logic         agValid,
    output logic         agReady,
    input  logic [47:0]  agAddr,
    input  logic [7:0]   idUIxt,
    input  logic         agStore,
    input  logic [63:0]  agData,
    input  logic         srT,
    output logic         memReqValid,
    input  logic         memReqReady,
    output logic [47:0]  memReqAddr,
    output logic [15:0]  memReqMask,
    output logic [127:0] memReqData,
    output logic         memReqStore,
    input  logic         memRespValid,
    input  logic [127:0] memRespData,
    output logic         ldValid,
    output logic [63:0]  ldData
);

    typedef enum logic [2:0] {
        IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE
    } state_e;

    state_e         state_q;
    logic [43:0]    line_q;
    logic [3:0]     off_q;
    logic [1:0]     size_q;
    logic           zext_q;
    logic           store_q;
    logic           split_q;
    logic [15:0]    mask1_q;
    logic [63:0]    data1_q;
    logic [127:0]   resp0_q;
    logic           req_valid_q;
    logic [47:0]    req_addr_q;
    logic [15:0]    req_mask_q;
    logic [127:0]   req_data_q;
    logic           req_store_q;
    logic           ld_valid_q;
    logic [63:0]    ld_data_q;

    logic [7:0]     bm8;
    logic [31:0]    mask32;
    logic [191:0]   data192;
    logic           cc_pass;
    logic [255:0]   line256;
    logic [63:0]    win;
    logic [63:0]    ld_d;
    logic           unused_ixt;

    assign unused_ixt = ^{idUIxt[3], idUIxt[1:0]};

    always_comb begin
        bm8 = 8'h01;
        unique case (idUIxt[5:4])
            2'd0: bm8 = 8'h01;
            2'd1: bm8 = 8'h03;
            2'd2: bm8 = 8'h0F;
            2'd3: bm8 = 8'hFF;
        endcase
        cc_pass = 1'b1;
        unique case (idUIxt[7:6])
            2'd0: cc_pass = 1'b1;
            2'd1: cc_pass = 1'b0;
            2'd2: cc_pass = srT;
            2'd3: cc_pass = !srT;
        endcase
    end

    assign mask32  = {24'h0, bm8} << agAddr[3:0];
    assign data192 = {128'h0, agData} << {agAddr[3:0], 3'b000};

    // Second half is the live response only when completing the split beat.
    assign line256 = (state_q == WAIT1) ? {memRespData, resp0_q}
                                        : {128'h0, memRespData};
    assign win = line256[{1'b0, off_q, 3'b000} +: 64];

    always_comb begin
        ld_d = win;
        unique case (size_q)
            2'd0: ld_d = zext_q ? {56'h0, win[7:0]}
                                : {{56{win[7]}}, win[7:0]};
            2'd1: ld_d = zext_q ? {48'h0, win[15:0]}
                                : {{48{win[15]}}, win[15:0]};
            2'd2: ld_d = zext_q ? {32'h0, win[31:0]}
                                : {{32{win[31]}}, win[31:0]};
            2'd3: ld_d = win;
        endcase
        if (store_q) ld_d = 64'h0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            line_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            zext_q      <= 1'b0;
            store_q     <= 1'b0;
            split_q     <= 1'b0;
            mask1_q     <= '0;
            data1_q     <= '0;
            resp0_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_mask_q  <= '0;
            req_data_q  <= '0;
            req_store_q <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: if (agValid) begin
                    line_q  <= agAddr[47:4];
                    off_q   <= agAddr[3:0];
                    size_q  <= idUIxt[5:4];
                    zext_q  <= idUIxt[2];
                    store_q <= agStore;
                    split_q <= |mask32[31:16];
                    mask1_q <= mask32[31:16];
                    data1_q <= data192[191:128];
                    if (cc_pass) begin
                        state_q     <= REQ0;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {agAddr[47:4], 4'h0};
                        req_mask_q  <= mask32[15:0];
                        req_data_q  <= data192[127:0];
                        req_store_q <= agStore;
                    end else begin
                        state_q    <= DONE;
                        ld_valid_q <= 1'b1;
                        ld_data_q  <= '0;
                    end
                end
                REQ0: if (memReqReady) begin
                    req_valid_q <= 1'b0;
                    state_q     <= WAIT0;
                end
                WAIT0: if (memRespValid) begin
                    resp0_q <= memRespData;
                    if (split_q) begin
                        state_q     <= REQ1;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= {line_q + 44'd1, 4'h0};
                        req_mask_q  <= mask1_q;
                        req_data_q  <= {64'h0, data1_q};
                    end else begin
                        state_q    <= DONE;
                        ld_valid_q <= 1'b1;
                        ld_data_q  <= ld_d;
                    end
                end
                REQ1: if (memReqReady) begin
                    req_valid_q <= 1'b0;
                    state_q     <= WAIT1;
                end
                WAIT1: if (memRespValid) begin
                    state_q    <= DONE;
                    ld_valid_q <= 1'b1;
                    ld_data_q  <= ld_d;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign agReady     = (state_q == IDLE);
    assign memReqValid = req_valid_q;
    assign memReqAddr  = req_addr_q;
    assign memReqMask  = req_mask_q;
    assign memReqData  = req_data_q;
    assign memReqStore = req_store_q;
    assign ldValid     = ld_valid_q;
    assign ldData      = ld_data_q;

endmodule

// File: tb/tb_ex_mem_split.sv
// tb_ex_mem_split: directed scenarios for ex_mem_split with
// hand-computed request fields, timing and load results.
module tb_ex_mem_split;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         agValid = 1'b0;
    logic         agReady;
    logic [47:0]  agAddr = '0;
    logic [7:0]   idUIxt = '0;
    logic         agStore = 1'b0;
    logic [63:0]  agData = '0;
    logic         srT = 1'b0;
    logic         memReqValid;
    logic         memReqReady = 1'b0;
    logic [47:0]  memReqAddr;
    logic [15:0]  memReqMask;
    logic [127:0] memReqData;
    logic         memReqStore;
    logic         memRespValid = 1'b0;
    logic [127:0] memRespData = '0;
    logic         ldValid;
    logic [63:0]  ldData;

    int n_run = 0;
    int n_fail = 0;

    ex_mem_split dut (
        .clock(clock), .reset(reset),
        .agValid(agValid), .agReady(agReady), .agAddr(agAddr),
        .idUIxt(idUIxt), .agStore(agStore), .agData(agData), .srT(srT),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqAddr(memReqAddr), .memReqMask(memReqMask),
        .memReqData(memReqData), .memReqStore(memReqStore),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .ldValid(ldValid), .ldData(ldData)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ixt(input logic [1:0] cc,
                                       input logic [1:0] sz,
                                       input logic z);
        return {cc, sz, 1'b0, z, 2'b00};
    endfunction

    // Presents one access; returns at the negedge of the first cycle after accept.
    task automatic issue(input logic [47:0] a, input logic [7:0] x,
                         input logic st, input logic [63:0] d, input logic t);
        @(negedge clock);
        agValid = 1'b1; agAddr = a; idUIxt = x;
        agStore = st; agData = d; srT = t;
        @(negedge clock);
        agValid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_run++; if (agReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", agReady); end
        n_run++; if (memReqValid !== 1'b0) begin n_fail++; $display("FAIL rst_reqvalid got=%b exp=0", memReqValid); end
        n_run++; if (ldValid !== 1'b0 || ldData !== 64'h0) begin n_fail++; $display("FAIL rst_ld got=%b/%h exp=0/0", ldValid, ldData); end
        n_run++; if (memReqAddr !== 48'h0 || memReqMask !== 16'h0 || memReqData !== 128'h0 || memReqStore !== 1'b0) begin n_fail++; $display("FAIL rst_fields got=%h/%h/%h/%b exp=0", memReqAddr, memReqMask, memReqData, memReqStore); end
        reset = 1'b1;
        @(negedge clock);
        n_run++; if (agReady !== 1'b1 || memReqValid !== 1'b0) begin n_fail++; $display("FAIL rst_release got=%b/%b exp=1/0", agReady, memReqValid); end
    endtask

    task automatic test_aligned_load();
        issue(48'h0000_1234_5008, ixt(2'd0, 2'd3, 1'b0), 1'b0, 64'h0, 1'b0);
        n_run++; if (memReqValid !== 1'b1 || agReady !== 1'b0) begin n_fail++; $display("FAIL al_req got=%b/%b exp=1/0", memReqValid, agReady); end
        n_run++; if (memReqAddr !== 48'h0000_1234_5000) begin n_fail++; $display("FAIL al_addr got=%h exp=%h", memReqAddr, 48'h0000_1234_5000); end
        n_run++; if (memReqMask !== 16'hFF00 || memReqStore !== 1'b0) begin n_fail++; $display("FAIL al_mask got=%h/%b exp=ff00/0", memReqMask, memReqStore); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        n_run++; if (memReqValid !== 1'b0 || ldValid !== 1'b0) begin n_fail++; $display("FAIL al_wait got=%b/%b exp=0/0", memReqValid, ldValid); end
        memRespValid = 1'b1;
        memRespData = {64'h8877665544332211, 64'hDEADBEEF0BADF00D};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b1) begin n_fail++; $display("FAIL al_ldvalid got=%b exp=1", ldValid); end
        n_run++; if (ldData !== 64'h8877665544332211) begin n_fail++; $display("FAIL al_lddata got=%h exp=%h", ldData, 64'h8877665544332211); end
        @(negedge clock);
        n_run++; if (ldValid !== 1'b0 || agReady !== 1'b1) begin n_fail++; $display("FAIL al_after got=%b/%b exp=0/1", ldValid, agReady); end
        n_run++; if (ldData !== 64'h8877665544332211) begin n_fail++; $display("FAIL al_hold got=%h exp=%h", ldData, 64'h8877665544332211); end
    endtask

    task automatic test_split_store();
        issue(48'h0000_1000_000C, ixt(2'd0, 2'd3, 1'b0), 1'b1, 64'h1122334455667788, 1'b0);
        n_run++; if (memReqValid !== 1'b1 || memReqStore !== 1'b1) begin n_fail++; $display("FAIL st_req got=%b/%b exp=1/1", memReqValid, memReqStore); end
        n_run++; if (memReqAddr !== 48'h0000_1000_0000 || memReqMask !== 16'hF000) begin n_fail++; $display("FAIL st_b0 got=%h/%h exp=%h/f000", memReqAddr, memReqMask, 48'h0000_1000_0000); end
        n_run++; if (memReqData !== {32'h55667788, 96'h0}) begin n_fail++; $display("FAIL st_b0data got=%h exp=%h", memReqData, {32'h55667788, 96'h0}); end
        @(negedge clock);
        n_run++; if (memReqValid !== 1'b1 || memReqMask !== 16'hF000 || memReqData !== {32'h55667788, 96'h0}) begin n_fail++; $display("FAIL st_stable got=%b/%h/%h exp=1/f000", memReqValid, memReqMask, memReqData); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        n_run++; if (memReqValid !== 1'b0) begin n_fail++; $display("FAIL st_w0 got=%b exp=0", memReqValid); end
        memRespValid = 1'b1;
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (memReqValid !== 1'b1 || memReqAddr !== 48'h0000_1000_0010 || memReqMask !== 16'h000F) begin n_fail++; $display("FAIL st_b1 got=%b/%h/%h exp=1/%h/000f", memReqValid, memReqAddr, memReqMask, 48'h0000_1000_0010); end
        n_run++; if (memReqData !== {96'h0, 32'h11223344}) begin n_fail++; $display("FAIL st_b1data got=%h exp=%h", memReqData, {96'h0, 32'h11223344}); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b1 || ldData !== 64'h0) begin n_fail++; $display("FAIL st_done got=%b/%h exp=1/0", ldValid, ldData); end
    endtask

    task automatic test_split_load(input logic z, input logic [63:0] exp);
        issue(48'h0000_0000_200F, ixt(2'd0, 2'd1, z), 1'b0, 64'h0, 1'b0);
        n_run++; if (memReqAddr !== 48'h2000 || memReqMask !== 16'h8000) begin n_fail++; $display("FAIL ld_b0 got=%h/%h exp=2000/8000", memReqAddr, memReqMask); end
        memReqReady = 1'b1;
        memRespValid = 1'b1;
        memRespData = {8'hEE, 120'h0};
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b0;
        n_run++; if (memReqValid !== 1'b0 || ldValid !== 1'b0) begin n_fail++; $display("FAIL ld_samecyc got=%b/%b exp=0/0", memReqValid, ldValid); end
        @(negedge clock);
        memRespValid = 1'b1;
        memRespData = {8'h80, 120'h0123456789ABCDEF0123456789ABCD};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (memReqValid !== 1'b1 || memReqAddr !== 48'h2010 || memReqMask !== 16'h0001) begin n_fail++; $display("FAIL ld_b1 got=%b/%h/%h exp=1/2010/0001", memReqValid, memReqAddr, memReqMask); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        memRespData = {120'h55AA55AA55AA55AA55AA55AA55AA55, 8'h91};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b1 || ldData !== exp) begin n_fail++; $display("FAIL ld_split_z%0d got=%b/%h exp=1/%h", z, ldValid, ldData, exp); end
    endtask

    task automatic test_suppressed();
        issue(48'h0000_0000_6000, ixt(2'd2, 2'd3, 1'b0), 1'b1, 64'hFFFF, 1'b0);
        n_run++; if (ldValid !== 1'b1 || ldData !== 64'h0 || memReqValid !== 1'b0) begin n_fail++; $display("FAIL sup_ct got=%b/%h/%b exp=1/0/0", ldValid, ldData, memReqValid); end
        @(negedge clock);
        n_run++; if (ldValid !== 1'b0 || memReqValid !== 1'b0 || agReady !== 1'b1) begin n_fail++; $display("FAIL sup_ct_after got=%b/%b/%b exp=0/0/1", ldValid, memReqValid, agReady); end
        issue(48'h0000_0000_6008, ixt(2'd1, 2'd2, 1'b0), 1'b0, 64'h0, 1'b1);
        n_run++; if (ldValid !== 1'b1 || ldData !== 64'h0 || memReqValid !== 1'b0) begin n_fail++; $display("FAIL sup_nv got=%b/%h/%b exp=1/0/0", ldValid, ldData, memReqValid); end
        issue(48'h0000_0000_6008, ixt(2'd3, 2'd2, 1'b0), 1'b0, 64'h0, 1'b1);
        n_run++; if (ldValid !== 1'b1 || memReqValid !== 1'b0) begin n_fail++; $display("FAIL sup_cf got=%b/%b exp=1/0", ldValid, memReqValid); end
    endtask

    task automatic test_cc_taken();
        issue(48'h0000_0000_5003, ixt(2'd2, 2'd0, 1'b0), 1'b0, 64'h0, 1'b1);
        n_run++; if (memReqValid !== 1'b1 || memReqMask !== 16'h0008) begin n_fail++; $display("FAIL ct_req got=%b/%h exp=1/0008", memReqValid, memReqMask); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        memRespData = {96'h0, 32'hF0123456};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b1 || ldData !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_fail++; $display("FAIL ct_byte got=%b/%h exp=1/fffffffffffffff0", ldValid, ldData); end
    endtask

    task automatic test_wrap();
        issue(48'hFFFF_FFFF_FFFC, ixt(2'd0, 2'd3, 1'b0), 1'b0, 64'h0, 1'b0);
        n_run++; if (memReqAddr !== 48'hFFFF_FFFF_FFF0 || memReqMask !== 16'hF000) begin n_fail++; $display("FAIL wr_b0 got=%h/%h exp=fffffffffff0/f000", memReqAddr, memReqMask); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        memRespData = {32'hA1B2C3D4, 96'h555555555555555555555555};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (memReqAddr !== 48'h0 || memReqMask !== 16'h000F || memReqValid !== 1'b1) begin n_fail++; $display("FAIL wr_b1 got=%h/%h/%b exp=0/000f/1", memReqAddr, memReqMask, memReqValid); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        memRespData = {96'h666666666666666666666666, 32'h0E0F1011};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b1 || ldData !== 64'h0E0F1011A1B2C3D4) begin n_fail++; $display("FAIL wr_data got=%b/%h exp=1/0e0f1011a1b2c3d4", ldValid, ldData); end
    endtask

    task automatic test_reset_midop();
        issue(48'h0000_0000_300E, ixt(2'd0, 2'd2, 1'b0), 1'b0, 64'h0, 1'b0);
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        @(negedge clock);
        memRespValid = 1'b0;
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        n_run++; if (memReqValid !== 1'b0 || agReady !== 1'b0) begin n_fail++; $display("FAIL mr_inwait1 got=%b/%b exp=0/0", memReqValid, agReady); end
        reset = 1'b0;
        #1;
        n_run++; if (agReady !== 1'b1 || memReqValid !== 1'b0 || ldValid !== 1'b0 || ldData !== 64'h0) begin n_fail++; $display("FAIL mr_rst got=%b/%b/%b/%h exp=1/0/0/0", agReady, memReqValid, ldValid, ldData); end
        n_run++; if (memReqAddr !== 48'h0 || memReqMask !== 16'h0 || memReqData !== 128'h0) begin n_fail++; $display("FAIL mr_fields got=%h/%h/%h exp=0", memReqAddr, memReqMask, memReqData); end
        @(negedge clock);
        reset = 1'b1;
        memRespValid = 1'b1;
        memRespData = {4{32'hBAD0BAD0}};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b0 || memReqValid !== 1'b0 || agReady !== 1'b1) begin n_fail++; $display("FAIL mr_stale got=%b/%b/%b exp=0/0/1", ldValid, memReqValid, agReady); end
        @(negedge clock);
        n_run++; if (ldValid !== 1'b0 || ldData !== 64'h0) begin n_fail++; $display("FAIL mr_stale2 got=%b/%h exp=0/0", ldValid, ldData); end
    endtask

    task automatic test_after_reset();
        issue(48'h0000_0000_4004, ixt(2'd0, 2'd2, 1'b1), 1'b0, 64'h0, 1'b0);
        n_run++; if (memReqValid !== 1'b1 || memReqAddr !== 48'h4000 || memReqMask !== 16'h00F0) begin n_fail++; $display("FAIL ar_req got=%b/%h/%h exp=1/4000/00f0", memReqValid, memReqAddr, memReqMask); end
        memReqReady = 1'b1;
        @(negedge clock);
        memReqReady = 1'b0;
        memRespValid = 1'b1;
        memRespData = {64'hFFFFFFFFFFFFFFFF, 32'hCAFEBABE, 32'h12345678};
        @(negedge clock);
        memRespValid = 1'b0;
        n_run++; if (ldValid !== 1'b1 || ldData !== 64'h0000_0000_CAFE_BABE) begin n_fail++; $display("FAIL ar_data got=%b/%h exp=1/00000000cafebabe", ldValid, ldData); end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_split_store();
        test_split_load(1'b0, 64'hFFFF_FFFF_FFFF_9180);
        test_split_load(1'b1, 64'h0000_0000_0000_9180);
        test_suppressed();
        test_cc_taken();
        test_wrap();
        test_reset_midop();
        test_after_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
